// File: rtl/div_clk_monitor.sv
// Self-check for a clk_in-synchronous divided clock: measures period and high time
// in clk_in cycles, tracks lock against expected values, flags mismatch and stuck clocks.
`timescale 1ns/1ps
module div_clk_monitor #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             clk_div,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [CNT_W-1:0] exp_high,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEASURE} state_t;

  localparam logic [3:0]       LOCK_MAX = 4'(LOCK_CNT);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  // Value one below saturation: p_cnt would reach all-ones on this cycle.
  localparam logic [CNT_W-1:0] P_LAST   = {{(CNT_W-1){1'b1}}, 1'b0};

  state_t           state;
  logic             d1;
  logic [CNT_W-1:0] p_cnt;
  logic [CNT_W-1:0] h_cnt;
  logic [3:0]       match_cnt;

  logic             rise;
  logic             is_match;
  logic             to_hit;
  logic             err_set;
  logic [3:0]       match_nxt;

  always_comb begin
    // NOTE: every signal written here gets a value on every path so no latch is inferred
    rise      = clk_div & ~d1;
    is_match  = (p_cnt == exp_period) && (h_cnt == exp_high);
    match_nxt = (match_cnt == LOCK_MAX) ? match_cnt : match_cnt + 4'd1;
    to_hit    = 1'b0;
    err_set   = 1'b0;
    if (en && state == MEASURE) begin
      to_hit  = !rise && (p_cnt == P_LAST);
      err_set = to_hit || (rise && !is_match && locked);
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      d1         <= 1'b0;
      p_cnt      <= '0;
      h_cnt      <= '0;
      match_cnt  <= '0;
      period_out <= '0;
      high_out   <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values
      d1         <= clk_div;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;

      // Set has priority over clear when both land in the same cycle.
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;

      if (!en) begin
        state     <= IDLE;
        p_cnt     <= '0;
        h_cnt     <= '0;
        match_cnt <= '0;
        locked    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: state <= WAIT_RISE;

          // The first rise only aligns the window; nothing is reported from it.
          WAIT_RISE: if (rise) begin
            p_cnt <= ONE;
            h_cnt <= ONE;
            state <= MEASURE;
          end

          MEASURE: begin
            if (rise) begin
              period_out <= p_cnt;
              high_out   <= h_cnt;
              meas_valid <= 1'b1;
              p_cnt      <= ONE;
              h_cnt      <= ONE;
              if (is_match) begin
                match_cnt <= match_nxt;
                locked    <= (match_nxt == LOCK_MAX);
              end else begin
                match_cnt <= '0;
                locked    <= 1'b0;
              end
            end else if (to_hit) begin
              timeout   <= 1'b1;
              match_cnt <= '0;
              locked    <= 1'b0;
              p_cnt     <= '0;
              h_cnt     <= '0;
              state     <= WAIT_RISE;
            end else begin
              p_cnt <= p_cnt + ONE;
              h_cnt <= h_cnt + CNT_W'(clk_div);
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
